// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
// Program counter with an integrated return-address stack.
//   - PC loads from increment, eabOut, Buss or the stack top (return).
//   - push saves PC+1 as a return address alongside the PC load (call).
//   - push together with return swaps the top entry with PC+1 (coroutine).
//   - Overflow/underflow raise stkErr one cycle after the offending cycle.
// Optional feature macro: PC_STACK_ERR_STICKY_EN
//   defined   -> stkErr stays high from the first error until reset
//   undefined -> stkErr is a one-cycle pulse per error cycle
// -----------------------------------------------------------------------------
module pc_stack_unit #(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ldPC,
   input  logic [1:0]                 selPC,
   input  logic                       push,
   input  logic [WIDTH-1:0]           Buss,
   input  logic [WIDTH-1:0]           eabOut,
   output logic [WIDTH-1:0]           PCOut,
   output logic [WIDTH-1:0]           stkTop,
   output logic [$clog2(DEPTH+1)-1:0] stkCount,
   output logic                       stkFull,
   output logic                       stkEmpty,
   output logic                       stkErr
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CNT_MAX  = CW'(DEPTH);
   localparam logic [WIDTH-1:0] PC_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] PC_ZERO  = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      SEL_INC = 2'b00,
      SEL_EAB = 2'b01,
      SEL_BUS = 2'b10,
      SEL_RET = 2'b11
   } sel_e;

   // Error flag update: sticky holds any earlier error, pulse mode tracks the
   // current cycle only.
   function automatic logic err_next(input logic err_cur, input logic event_now);
`ifdef PC_STACK_ERR_STICKY_EN
      return err_cur | event_now;
`else
      return event_now & ~(err_cur & 1'b0);
`endif
   endfunction

   // State registers
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] stk_mem_q [DEPTH];

   // Derived / control signals
   logic [WIDTH-1:0] pc_inc_s;
   logic [WIDTH-1:0] top_s;
   logic [IW-1:0]    top_idx_s;
   logic [IW-1:0]    wr_idx_s;
   logic [WIDTH-1:0] wr_data_s;
   logic             wr_en_s;
   logic             empty_s;
   logic             full_s;
   logic             ovf_s;
   logic             unf_s;

   assign pc_inc_s  = pc_q + PC_ONE;
   assign empty_s   = (cnt_q == CNT_ZERO);
   assign full_s    = (cnt_q == CNT_MAX);
   assign top_idx_s = IW'(cnt_q - CNT_ONE);

   // Top-of-stack view: entries beyond the count are stale, so an empty
   // stack always reads as zero regardless of what storage holds.
   always_comb begin
      top_s = PC_ZERO;
      if (empty_s) begin
         top_s = PC_ZERO;
      end else begin
         top_s = stk_mem_q[top_idx_s];
      end
   end

   // Next-state decode for PC, stack pointer, stack write port and error.
   always_comb begin
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      wr_en_s   = 1'b0;
      wr_idx_s  = IW'(cnt_q);
      wr_data_s = pc_inc_s;
      ovf_s     = 1'b0;
      unf_s     = 1'b0;

      if (ldPC) begin
         case (selPC)
            SEL_INC: pc_d = pc_inc_s;
            SEL_EAB: pc_d = eabOut;
            SEL_BUS: pc_d = Buss;
            SEL_RET: begin
               if (empty_s) begin
                  // Underflow: PC holds, nothing is pushed even with push=1.
                  unf_s = 1'b1;
               end else begin
                  pc_d = top_s;
                  if (push) begin
                     // Swap: overwrite the top in place, depth unchanged.
                     wr_en_s  = 1'b1;
                     wr_idx_s = top_idx_s;
                  end else begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
            end
            default: pc_d = pc_q;
         endcase

         // Call: the return address is pushed alongside the PC load. A full
         // stack still takes the PC load but drops the push.
         if (push && (selPC != SEL_RET)) begin
            if (full_s) begin
               ovf_s = 1'b1;
            end else begin
               wr_en_s  = 1'b1;
               wr_idx_s = IW'(cnt_q);
               cnt_d    = cnt_q + CNT_ONE;
            end
         end else begin
            wr_data_s = pc_inc_s;
         end
      end else begin
         pc_d  = pc_q;
         cnt_d = cnt_q;
      end

      err_d = err_next(err_q, ovf_s | unf_s);
   end

   // PC, stack depth and error flag; reset wins over every other control.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_VEC;
         cnt_q <= CNT_ZERO;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Stack entry storage; not cleared on reset since the depth counter
   // already marks every entry as invalid.
   always_ff @(posedge clk) begin
      if (!reset && wr_en_s) begin
         stk_mem_q[wr_idx_s] <= wr_data_s;
      end else begin
         stk_mem_q[wr_idx_s] <= stk_mem_q[wr_idx_s];
      end
   end

   assign PCOut    = pc_q;
   assign stkTop   = top_s;
   assign stkCount = cnt_q;
   assign stkFull  = (stkCount == CNT_MAX);
   assign stkEmpty = (stkCount == CNT_ZERO);
   assign stkErr   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pc_stack_unit (default parameters).
// A behavioural model (queue-based stack) predicts the outputs of every
// cycle; predictions and sampled outputs are queued and compared per task.
// -----------------------------------------------------------------------------
module tb_pc_stack_unit;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             ldPC;
   logic [1:0]       selPC;
   logic             push;
   logic [WIDTH-1:0] Buss;
   logic [WIDTH-1:0] eabOut;
   logic [WIDTH-1:0] PCOut;
   logic [WIDTH-1:0] stkTop;
   logic [CW-1:0]    stkCount;
   logic             stkFull;
   logic             stkEmpty;
   logic             stkErr;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] top;
      logic [CW-1:0]    cnt;
      logic             full;
      logic             empty;
      logic             err;
   } snap_t;

   snap_t exp_q[$];
   snap_t obs_q[$];
   int    checks = 0;
   int    errors = 0;

   logic [WIDTH-1:0] m_pc;
   logic [WIDTH-1:0] m_stk[$];
   logic             m_err;

   pc_stack_unit dut (
      .clk(clk), .reset(reset), .ldPC(ldPC), .selPC(selPC), .push(push),
      .Buss(Buss), .eabOut(eabOut), .PCOut(PCOut), .stkTop(stkTop),
      .stkCount(stkCount), .stkFull(stkFull), .stkEmpty(stkEmpty), .stkErr(stkErr)
   );

   always #5 clk = ~clk;

   // Drive one cycle, push the model prediction, sample outputs after the edge.
   task automatic drive(input logic rst, input logic ld, input logic [1:0] sel,
                        input logic psh, input logic [WIDTH-1:0] bus,
                        input logic [WIDTH-1:0] eab);
      logic [WIDTH-1:0] inc;
      logic [WIDTH-1:0] old;
      logic             ev;
      snap_t            e;
      reset = rst; ldPC = ld; selPC = sel; push = psh; Buss = bus; eabOut = eab;
      ev = 1'b0;
      if (rst) begin
         m_pc = 16'h0000;
         m_stk.delete();
         m_err = 1'b0;
      end else begin
         if (ld) begin
            inc = m_pc + 16'h0001;
            case (sel)
               2'b00: m_pc = inc;
               2'b01: m_pc = eab;
               2'b10: m_pc = bus;
               default: begin
                  if (m_stk.size() == 0) begin
                     ev = 1'b1;
                  end else begin
                     old = m_stk[m_stk.size()-1];
                     if (psh) m_stk[m_stk.size()-1] = inc;
                     else void'(m_stk.pop_back());
                     m_pc = old;
                  end
               end
            endcase
            if (psh && sel != 2'b11) begin
               if (m_stk.size() == DEPTH) ev = 1'b1;
               else m_stk.push_back(inc);
            end
         end
`ifdef PC_STACK_ERR_STICKY_EN
         m_err = m_err | ev;
`else
         m_err = ev;
`endif
      end
      e.pc    = m_pc;
      e.top   = (m_stk.size() == 0) ? 16'h0000 : m_stk[m_stk.size()-1];
      e.cnt   = CW'(m_stk.size());
      e.full  = (m_stk.size() == DEPTH);
      e.empty = (m_stk.size() == 0);
      e.err   = m_err;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      obs_q.push_back({PCOut, stkTop, stkCount, stkFull, stkEmpty, stkErr});
   endtask

   task automatic test_reset();
      snap_t o, e;
      drive(1'b1, 1'b1, 2'b10, 1'b1, 16'h5555, 16'h6666);
      drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (PCOut !== 16'h0000 || stkCount !== 4'd0 || stkTop !== 16'h0000 || stkErr !== 1'b0) begin
         errors++;
         $display("FAIL reset_state pc=%h cnt=%0d top=%h err=%b want 0000/0/0000/0", PCOut, stkCount, stkTop, stkErr);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL reset got %h exp %h", o, e); end
      end
   endtask

   task automatic test_increment();
      snap_t o, e;
      drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (PCOut !== 16'h0003) begin errors++; $display("FAIL inc_3 got %h want 0003", PCOut); end
      drive(1'b0, 1'b1, 2'b01, 1'b0, 16'h0000, 16'hFFFF);
      drive(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (PCOut !== 16'h0000 || stkErr !== 1'b0) begin
         errors++; $display("FAIL inc_wrap got pc=%h err=%b want 0000/0", PCOut, stkErr);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL increment got %h exp %h", o, e); end
      end
   endtask

   task automatic test_call_return();
      snap_t o, e;
      drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
      drive(1'b0, 1'b1, 2'b10, 1'b0, 16'h3000, 16'h0000);
      drive(1'b0, 1'b1, 2'b10, 1'b1, 16'h4000, 16'h0000);
      checks++;
      if (PCOut !== 16'h4000 || stkTop !== 16'h3001 || stkCount !== 4'd1) begin
         errors++; $display("FAIL call got pc=%h top=%h cnt=%0d want 4000/3001/1", PCOut, stkTop, stkCount);
      end
      drive(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (PCOut !== 16'h3001 || stkEmpty !== 1'b1) begin
         errors++; $display("FAIL return got pc=%h empty=%b want 3001/1", PCOut, stkEmpty);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL call_return got %h exp %h", o, e); end
      end
   endtask

   task automatic test_hold();
      snap_t o, e;
      drive(1'b0, 1'b1, 2'b10, 1'b1, 16'h0ABC, 16'h0000);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 2'(i + 1), 1'b1, 16'hFFFF, 16'hEEEE);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL hold got %h exp %h", o, e); end
      end
   endtask

   task automatic test_overflow();
      snap_t o, e;
      drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 2'b10, 1'b1, 16'h1000 + 16'(i * 16), 16'h0000);
      checks++;
      if (stkFull !== 1'b1 || stkErr !== 1'b0) begin
         errors++; $display("FAIL fill got full=%b err=%b want 1/0", stkFull, stkErr);
      end
      drive(1'b0, 1'b1, 2'b10, 1'b1, 16'hABCD, 16'h0000);
      checks++;
      if (PCOut !== 16'hABCD || stkCount !== 4'd8 || stkTop !== 16'h1061 || stkErr !== 1'b1) begin
         errors++; $display("FAIL overflow got pc=%h cnt=%0d top=%h err=%b want ABCD/8/1061/1", PCOut, stkCount, stkTop, stkErr);
      end
      drive(1'b0, 1'b1, 2'b01, 1'b1, 16'h0000, 16'h1234);
      checks++;
      if (stkErr !== 1'b1) begin errors++; $display("FAIL overflow_again got err=%b want 1", stkErr); end
      drive(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL overflow_seq got %h exp %h", o, e); end
      end
   endtask

   task automatic test_underflow();
      snap_t o, e;
      drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
      drive(1'b0, 1'b1, 2'b10, 1'b0, 16'h1234, 16'h0000);
      drive(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (PCOut !== 16'h1234 || stkErr !== 1'b1) begin
         errors++; $display("FAIL underflow got pc=%h err=%b want 1234/1", PCOut, stkErr);
      end
      drive(1'b0, 1'b1, 2'b11, 1'b1, 16'h0000, 16'h0000);
      checks++;
      if (stkCount !== 4'd0 || stkErr !== 1'b1) begin
         errors++; $display("FAIL underflow_push got cnt=%0d err=%b want 0/1", stkCount, stkErr);
      end
      drive(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000);
      checks++;
`ifdef PC_STACK_ERR_STICKY_EN
      if (stkErr !== 1'b1) begin errors++; $display("FAIL err_after got %b want 1", stkErr); end
`else
      if (stkErr !== 1'b0) begin errors++; $display("FAIL err_after got %b want 0", stkErr); end
`endif
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL underflow_seq got %h exp %h", o, e); end
      end
   endtask

   task automatic test_swap();
      snap_t o, e;
      drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
      drive(1'b0, 1'b1, 2'b10, 1'b0, 16'h4FFF, 16'h0000);
      drive(1'b0, 1'b1, 2'b10, 1'b1, 16'h2000, 16'h0000);
      drive(1'b0, 1'b1, 2'b11, 1'b1, 16'h0000, 16'h0000);
      checks++;
      if (PCOut !== 16'h5000 || stkTop !== 16'h2001 || stkCount !== 4'd1) begin
         errors++; $display("FAIL swap got pc=%h top=%h cnt=%0d want 5000/2001/1", PCOut, stkTop, stkCount);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL swap_seq got %h exp %h", o, e); end
      end
   endtask

   task automatic test_reset_mid();
      snap_t o, e;
      drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'b00, 1'b1, 16'h0000, 16'h0000);
      drive(1'b1, 1'b1, 2'b10, 1'b1, 16'h7777, 16'h0000);
      checks++;
      if (PCOut !== 16'h0000 || stkCount !== 4'd0 || stkTop !== 16'h0000 || stkErr !== 1'b0) begin
         errors++; $display("FAIL reset_mid got pc=%h cnt=%0d top=%h err=%b", PCOut, stkCount, stkTop, stkErr);
      end
      drive(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL reset_mid_seq got %h exp %h", o, e); end
      end
   endtask

   task automatic test_random();
      snap_t o, e;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 9) < 5), 16'($urandom), 16'($urandom));
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL random got %h exp %h", o, e); end
      end
   endtask

   initial begin
      reset = 1'b1; ldPC = 1'b0; selPC = 2'b00; push = 1'b0;
      Buss = 16'h0000; eabOut = 16'h0000;
      m_pc = 16'h0000; m_err = 1'b0;
      test_reset();
      test_increment();
      test_call_return();
      test_hold();
      test_overflow();
      test_underflow();
      test_swap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning PC and data path width in bits (minimum 4).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning return-address stack entries (minimum 2).
REQ-003 The block SHALL have parameter RESET_VEC, default 0, meaning the WIDTH-bit PC value loaded on reset.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port ldPC  input  1  PC load enable; all PC and stack updates require ldPC=1.
REQ-007 The block SHALL have port selPC  input  2  next-PC source: 00 increment, 01 eabOut, 10 Buss, 11 return (stack pop).
REQ-008 The block SHALL have port push  input  1  call marker; saves return address when ldPC=1.
REQ-009 The block SHALL have port Buss  input  WIDTH  bus value for selPC=10.
REQ-010 The block SHALL have port eabOut  input  WIDTH  effective-address value for selPC=01.
REQ-011 The block SHALL have port PCOut  output  WIDTH  registered program counter.
REQ-012 The block SHALL have port stkTop  output  WIDTH  top stack entry; all zeros when empty.
REQ-013 The block SHALL have port stkCount  output  $clog2(DEPTH+1)  occupied entries.
REQ-014 The block SHALL have ports stkFull and stkEmpty  output  1 each  stkCount==DEPTH and stkCount==0, combinational from stkCount.
REQ-015 The block SHALL have port stkErr  output  1  registered overflow/underflow indication.

Function
REQ-016 All state SHALL update on the rising clk edge only; a load issued in cycle N SHALL be visible on PCOut in cycle N+1.
REQ-017 With ldPC=0, PCOut, stack contents, and stkCount SHALL hold; push and selPC SHALL be ignored.
REQ-018 Increment (selPC=00) SHALL load PCOut+1 modulo 2^WIDTH; all ones SHALL wrap to zero with no flag.
REQ-019 selPC=01 SHALL load eabOut; selPC=10 SHALL load Buss.
REQ-020 selPC=11 with stack non-empty SHALL load stkTop into PCOut and decrement stkCount.
REQ-021 selPC=11 with stack empty (underflow) SHALL hold PCOut and raise the error of REQ-026.
REQ-022 push=1 with selPC in {00,01,10} and stack not full SHALL write PCOut+1 (wrapped) as the new top and increment stkCount, concurrently with the PC load.
REQ-023 push=1 with stack full (overflow) SHALL still perform the PC load, SHALL leave stack and stkCount unchanged, and SHALL raise the error of REQ-026.
REQ-024 push=1 with selPC=11 and stack non-empty (swap) SHALL load old stkTop into PCOut, replace the top with PCOut+1, and leave stkCount unchanged.
REQ-025 push=1 with selPC=11 and stack empty SHALL be treated as underflow per REQ-021; nothing SHALL be pushed.
REQ-026 An overflow or underflow event in cycle N SHALL assert stkErr in cycle N+1.

Reset
REQ-027 reset=1 at a clock edge SHALL set PCOut=RESET_VEC, stkCount=0, and stkErr=0, overriding ldPC, push, and selPC.
REQ-028 Reset asserted mid-sequence SHALL discard all stack contents logically; entry storage need not be cleared, but stkTop SHALL read zero while empty.

Configuration
REQ-029 Macro PC_STACK_ERR_STICKY_EN: when defined, stkErr SHALL remain 1 after the first error until reset.
REQ-030 When PC_STACK_ERR_STICKY_EN is undefined, stkErr SHALL be a one-cycle pulse per error cycle, re-asserting on each consecutive error.

Verification
REQ-031 Reset then ldPC=1, selPC=00 for 3 cycles -> PCOut 0,1,2,3; with PCOut=FFFF, one more increment -> 0000.
REQ-032 PCOut=0x3000, ldPC=1, push=1, selPC=10, Buss=0x4000 -> PCOut=0x4000, stkTop=0x3001, stkCount=1; next selPC=11 -> PCOut=0x3001, stkEmpty=1.
REQ-033 Push DEPTH=8 times, then push a 9th -> stkFull=1, stkCount stays 8, PC loads, and stkErr=1 next cycle; stkTop unchanged.
REQ-034 Empty stack with selPC=11 -> PCOut holds and stkErr=1 next cycle; with the macro undefined, stkErr=0 a cycle later; with it defined, stkErr stays 1 until reset.
REQ-035 Swap case: stkTop=0x5000, PCOut=0x2000, push=1, selPC=11 -> PCOut=0x5000, stkTop=0x2001, stkCount unchanged.
REQ-036 With stkCount=3, assert reset together with ldPC=1, push=1 -> PCOut=RESET_VEC, stkCount=0, stkTop=0, stkErr=0.
